// File: rtl/instr_encoder_if.sv
// Request and memory-write bus of the instruction encoder.
// The slave modport is the encoder side; the master modport is the host/memory side.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        op_in;
   logic              imm_mode;
   logic [3:0]        rdest_in;
   logic [3:0]        rsrc_in;
   logic [15:0]       imm_in;
   logic [15:0]       instr_out;
   logic              instr_valid;
   logic              instr_ready;
   logic [ADDR_W-1:0] addr_out;
   logic              err;

   modport slave (
      input  req_valid, op_in, imm_mode, rdest_in, rsrc_in, imm_in, instr_ready,
      output req_ready, instr_out, instr_valid, addr_out, err
   );

   modport master (
      output req_valid, op_in, imm_mode, rdest_in, rsrc_in, imm_in, instr_ready,
      input  req_ready, instr_out, instr_valid, addr_out, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: turns one abstract operation into 1..3 machine words
// (wide immediates expand to LUI/ORI sequences) with a sequential write address.
module instr_encoder #(
   parameter int          ADDR_W      = 8,
   parameter logic [3:0]  SCRATCH_REG = 4'hF
) (
   input  logic            clk,
   input  logic            reset_n,
   instr_encoder_if.slave  bus
);
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_LSH  = 4'b0100;
   localparam logic [3:0] OP_ADD  = 4'b0101;
   localparam logic [3:0] OP_ASHU = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b1001;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_MOV  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;
   localparam logic [3:0] OP_LUI  = 4'b1111;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t            state_r;
   logic [15:0]       word1_r;
   logic [15:0]       word2_r;
   logic [1:0]        len_r;
   logic [1:0]        idx_r;
   logic [15:0]       instr_out_r;
   logic              instr_valid_r;
   logic [ADDR_W-1:0] addr_r;
   logic              err_r;

   logic [15:0] enc_w0_s;
   logic [15:0] enc_w1_s;
   logic [15:0] enc_w2_s;
   logic [1:0]  enc_len_s;
   logic        enc_bad_s;
   logic        need3_s;
   logic        sfit_s;
   logic        ufit_s;
   logic [7:0]  hi_s;
   logic [7:0]  lo_s;
   logic        last_s;
   logic        req_ready_s;
   logic        accept_s;
   logic        load_s;
   logic [15:0] next_word_s;

   // Encode the presented request into its word sequence and legality.
   always_comb begin
      enc_w0_s  = 16'h0000;
      enc_w1_s  = 16'h0000;
      enc_w2_s  = 16'h0000;
      enc_len_s = 2'd1;
      enc_bad_s = 1'b0;
      need3_s   = 1'b0;
      hi_s      = bus.imm_in[15:8];
      lo_s      = bus.imm_in[7:0];
      sfit_s    = (&bus.imm_in[15:7]) | ~(|bus.imm_in[15:7]);
      ufit_s    = ~(|bus.imm_in[15:8]);
      if (!bus.imm_mode) begin
         case (bus.op_in)
            OP_LSH, OP_ASHU:
               enc_w0_s = {4'b1000, bus.rdest_in, bus.op_in, bus.rsrc_in};
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV, OP_MUL:
               enc_w0_s = {4'b0000, bus.rdest_in, bus.op_in, bus.rsrc_in};
            default:
               enc_bad_s = 1'b1;
         endcase
      end else begin
         case (bus.op_in)
            OP_LUI: begin
               enc_w0_s  = {OP_LUI, bus.rdest_in, lo_s};
               enc_bad_s = ~ufit_s;
            end
            OP_ADD, OP_SUB, OP_CMP, OP_MUL: begin
               if (sfit_s) begin
                  enc_w0_s = {bus.op_in, bus.rdest_in, lo_s};
               end else begin
                  need3_s = 1'b1;
               end
            end
            OP_AND, OP_OR, OP_XOR: begin
               if (ufit_s) begin
                  enc_w0_s = {bus.op_in, bus.rdest_in, lo_s};
               end else begin
                  need3_s = 1'b1;
               end
            end
            OP_MOV: begin
               if (ufit_s) begin
                  enc_w0_s = {bus.op_in, bus.rdest_in, lo_s};
               end else begin
                  enc_len_s = 2'd2;
                  enc_w0_s  = {OP_LUI, bus.rdest_in, hi_s};
                  enc_w1_s  = {OP_OR, bus.rdest_in, lo_s};
               end
            end
            default:
               enc_bad_s = 1'b1;
         endcase
      end
      // The scratch register is built up first, so it cannot also be the destination.
      if (need3_s) begin
         enc_len_s = 2'd3;
         enc_w0_s  = {OP_LUI, SCRATCH_REG, hi_s};
         enc_w1_s  = {OP_OR, SCRATCH_REG, lo_s};
         enc_w2_s  = {4'b0000, bus.rdest_in, bus.op_in, SCRATCH_REG};
         enc_bad_s = (bus.rdest_in == SCRATCH_REG);
      end else begin
         enc_len_s = enc_len_s;
      end
   end

   // Handshake decode and selection of the word following the current one.
   always_comb begin
      last_s      = (idx_r == (len_r - 2'd1));
      req_ready_s = reset_n & ((state_r == IDLE) |
                               ((state_r == EMIT) & last_s & bus.instr_ready));
      accept_s    = bus.req_valid & req_ready_s;
      load_s      = accept_s & ~enc_bad_s;
      if (idx_r == 2'd0) begin
         next_word_s = word1_r;
      end else begin
         next_word_s = word2_r;
      end
   end

   // Sequencer FSM with registered word, address and error outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= IDLE;
         word1_r       <= 16'h0000;
         word2_r       <= 16'h0000;
         len_r         <= 2'd1;
         idx_r         <= 2'd0;
         instr_out_r   <= 16'h0000;
         instr_valid_r <= 1'b0;
         addr_r        <= {ADDR_W{1'b0}};
         err_r         <= 1'b0;
      end else begin
         err_r <= accept_s & enc_bad_s;
         case (state_r)
            IDLE: begin
               if (load_s) begin
                  word1_r       <= enc_w1_s;
                  word2_r       <= enc_w2_s;
                  len_r         <= enc_len_s;
                  idx_r         <= 2'd0;
                  instr_out_r   <= enc_w0_s;
                  instr_valid_r <= 1'b1;
                  state_r       <= EMIT;
               end else begin
                  instr_valid_r <= 1'b0;
               end
            end
            EMIT: begin
               if (bus.instr_ready) begin
                  addr_r <= addr_r + ADDR_ONE;
                  if (last_s && load_s) begin
                     word1_r     <= enc_w1_s;
                     word2_r     <= enc_w2_s;
                     len_r       <= enc_len_s;
                     idx_r       <= 2'd0;
                     instr_out_r <= enc_w0_s;
                  end else if (last_s) begin
                     instr_valid_r <= 1'b0;
                     state_r       <= IDLE;
                  end else begin
                     idx_r       <= idx_r + 2'd1;
                     instr_out_r <= next_word_s;
                  end
               end else begin
                  instr_out_r <= instr_out_r;
               end
            end
            default: begin
               instr_valid_r <= 1'b0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_s;
   assign bus.instr_out   = instr_out_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.addr_out    = addr_r;
   assign bus.err         = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: an instruction-level model feeds a word
// scoreboard checked every cycle, plus directed vectors with hand-computed words.
module tb_instr_encoder;
   localparam int AW  = 4;
   localparam int SCR = 15;

   typedef struct {
      bit               bad;
      int               n;
      logic [2:0][15:0] w;
   } exp_t;

   typedef struct {
      logic [15:0] word;
      int          addr;
      int          cyc;
   } wr_t;

   logic clk;
   logic reset_n;
   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;
   int   err_seen   = 0;
   int   exp_addr   = 0;
   bit   err_exp    = 1'b0;
   logic [15:0] expq[$];
   wr_t         wlog[$];

   instr_encoder_if #(.ADDR_W(AW)) bus();

   instr_encoder #(.ADDR_W(AW), .SCRATCH_REG(4'hF)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction-level reference: what the word sequence must be for one request.
   function automatic exp_t model(int op, bit imode, int rd, int rs, int imm);
      exp_t e;
      int   simm;
      bit   fits;
      e.bad = 1'b0;
      e.n   = 1;
      e.w   = '0;
      simm  = (imm >= 32768) ? imm - 65536 : imm;
      if (!(op inside {1, 2, 3, 4, 5, 6, 9, 11, 13, 14, 15})) begin
         e.bad = 1'b1;
      end else if (!imode) begin
         if (op == 15) e.bad = 1'b1;
         else if (op == 4 || op == 6) e.w[0] = 16'(32768 + rd * 256 + op * 16 + rs);
         else e.w[0] = 16'(rd * 256 + op * 16 + rs);
      end else if (op == 4 || op == 6) begin
         e.bad = 1'b1;
      end else if (op == 15) begin
         if (imm > 255) e.bad = 1'b1;
         else e.w[0] = 16'(61440 + rd * 256 + imm);
      end else begin
         fits = (op inside {5, 9, 11, 14}) ? (simm >= -128 && simm <= 127) : (imm < 256);
         if (fits) begin
            e.w[0] = 16'(op * 4096 + rd * 256 + imm % 256);
         end else if (op == 13) begin
            e.n    = 2;
            e.w[0] = 16'(61440 + rd * 256 + imm / 256);
            e.w[1] = 16'(8192 + rd * 256 + imm % 256);
         end else if (rd == SCR) begin
            e.bad = 1'b1;
         end else begin
            e.n    = 3;
            e.w[0] = 16'(61440 + SCR * 256 + imm / 256);
            e.w[1] = 16'(8192 + SCR * 256 + imm % 256);
            e.w[2] = 16'(rd * 256 + op * 16 + SCR);
         end
      end
      return e;
   endfunction

   // Per-cycle compare against the model, sampled on the falling edge.
   initial begin
      exp_t e;
      wr_t  r;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_instr_valid", bus.instr_valid, 0);
            chk("rst_instr_out", bus.instr_out, 0);
            chk("rst_addr", bus.addr_out, 0);
            chk("rst_err", bus.err, 0);
            expq.delete();
            exp_addr = 0;
            err_exp  = 1'b0;
         end else begin
            chk("instr_valid", bus.instr_valid, expq.size() != 0);
            chk("req_ready", bus.req_ready,
                (expq.size() == 0) || (expq.size() == 1 && bus.instr_ready));
            chk("err", bus.err, err_exp);
            if (expq.size() != 0) begin
               chk("instr_out", bus.instr_out, expq[0]);
               chk("addr_out", bus.addr_out, exp_addr);
            end
            if (bus.err) err_seen++;
            err_exp = 1'b0;
            if (bus.instr_valid && bus.instr_ready) begin
               r.word = bus.instr_out;
               r.addr = int'(bus.addr_out);
               r.cyc  = cyc;
               wlog.push_back(r);
               if (expq.size() != 0) void'(expq.pop_front());
               exp_addr = (exp_addr + 1) % (1 << AW);
            end
            if (bus.req_valid && bus.req_ready) begin
               e = model(int'(bus.op_in), bus.imm_mode, int'(bus.rdest_in),
                         int'(bus.rsrc_in), int'(bus.imm_in));
               if (e.bad) err_exp = 1'b1;
               else for (int k = 0; k < e.n; k++) expq.push_back(e.w[k]);
            end
         end
      end
   end

   task automatic send(input int op, input bit im, input int rd, input int rs, input int imm);
      bit got;
      got          = 1'b0;
      bus.op_in    = 4'(op);
      bus.imm_mode = im;
      bus.rdest_in = 4'(rd);
      bus.rsrc_in  = 4'(rs);
      bus.imm_in   = 16'(imm);
      bus.req_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("accept", got, 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (!bus.instr_valid && expq.size() == 0) begin
            idle = 1'b1;
            break;
         end
      end
      chk("idle_timeout", idle, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input int i, input logic [15:0] w, input int a);
      if (wlog.size() > i) begin
         chk($sformatf("wr%0d_word", i), wlog[i].word, w);
         chk($sformatf("wr%0d_addr", i), wlog[i].addr, a);
      end else begin
         chk("wlog_size", wlog.size(), i + 1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   es;
      reset_n         = 1'b0;
      bus.req_valid   = 1'b0;
      bus.op_in       = 4'h0;
      bus.imm_mode    = 1'b0;
      bus.rdest_in    = 4'h0;
      bus.rsrc_in     = 4'h0;
      bus.imm_in      = 16'h0000;
      bus.instr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_instr_out", bus.instr_out, 16'h0000);
      chk("post_rst_addr", bus.addr_out, 0);
      chk("post_rst_req_ready", bus.req_ready, 1);
      chk("post_rst_valid", bus.instr_valid, 0);
      chk("post_rst_err", bus.err, 0);

      // Pin the model with hand-computed words.
      e = model(5, 0, 3, 7, 0);
      chk("model_add_reg", e.w[0], 16'h0357);
      e = model(13, 1, 4, 0, 16'h1234);
      chk("model_mov_n", e.n, 2);
      chk("model_mov_w0", e.w[0], 16'hF412);
      chk("model_mov_w1", e.w[1], 16'h2434);
      e = model(11, 1, 5, 0, 16'h0080);
      chk("model_cmp_w2", e.w[2], 16'h05BF);
      e = model(1, 1, 15, 0, 16'h1200);
      chk("model_andi_r15_bad", e.bad, 1);

      @(posedge clk);
      #1;
      // Register forms
      send(5, 0, 3, 7, 0);
      send(4, 0, 2, 1, 0);
      wait_idle();
      chk_wr(0, 16'h0357, 0);
      chk_wr(1, 16'h8241, 1);

      // Signed immediates
      send(5, 1, 2, 0, 16'hFFFD);
      send(11, 1, 5, 0, 16'h0080);
      wait_idle();
      chk_wr(2, 16'h52FD, 2);
      chk_wr(3, 16'hFF00, 3);
      chk_wr(4, 16'h2F80, 4);
      chk_wr(5, 16'h05BF, 5);

      // Wide MOV and wide AND
      send(13, 1, 4, 0, 16'h1234);
      wait_idle();
      chk_wr(6, 16'hF412, 6);
      chk_wr(7, 16'h2434, 7);
      send(1, 1, 1, 0, 16'h0F00);
      wait_idle();
      chk_wr(8, 16'hFF0F, 8);
      chk_wr(9, 16'h2F00, 9);
      chk_wr(10, 16'h011F, 10);

      // Backpressure during word 2 of ADDI R6,0x1234
      send(5, 1, 6, 0, 16'h1234);
      @(posedge clk);
      #1;
      bus.instr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_hold_word", bus.instr_out, 16'h2F34);
      chk("bp_hold_addr", bus.addr_out, 12);
      chk("bp_writes", wlog.size(), 12);
      bus.instr_ready = 1'b1;
      wait_idle();
      chk("bp_total_writes", wlog.size(), 14);
      chk_wr(11, 16'hFF12, 11);
      chk_wr(12, 16'h2F34, 12);
      chk_wr(13, 16'h065F, 13);

      // Back-to-back single words across the address wrap
      send(3, 1, 1, 0, 16'h0011);
      send(3, 1, 1, 0, 16'h0022);
      send(3, 1, 1, 0, 16'h0033);
      send(3, 1, 1, 0, 16'h0044);
      wait_idle();
      chk_wr(14, 16'h3111, 14);
      chk_wr(15, 16'h3122, 15);
      chk_wr(16, 16'h3133, 0);
      chk_wr(17, 16'h3144, 1);
      if (wlog.size() >= 18) begin
         for (int k = 14; k < 17; k++)
            chk($sformatf("stream_gap%0d", k), wlog[k+1].cyc - wlog[k].cyc, 1);
      end else begin
         chk("stream_size", wlog.size(), 18);
      end

      // Illegal requests
      es = err_seen;
      send(4, 1, 2, 0, 3);
      repeat (3) @(posedge clk);
      #1;
      chk("err_lsh_imm", err_seen - es, 1);
      send(1, 1, 15, 0, 16'h1200);
      send(15, 0, 1, 2, 0);
      send(0, 0, 1, 2, 0);
      send(15, 1, 3, 0, 16'h0100);
      repeat (3) @(posedge clk);
      #1;
      chk("err_pulses", err_seen - es, 5);
      chk("no_words_on_err", wlog.size(), 18);
      send(15, 1, 3, 0, 16'h00AB);
      wait_idle();
      chk_wr(18, 16'hF3AB, 2);

      // Reset during word 2 of a 3-word sequence
      send(1, 1, 1, 0, 16'h0F00);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_valid", bus.instr_valid, 0);
      chk("rst_mid_addr", bus.addr_out, 0);
      chk("rst_mid_req_ready", bus.req_ready, 0);
      chk("rst_mid_writes", wlog.size(), 20);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      send(5, 0, 3, 7, 0);
      wait_idle();
      chk_wr(20, 16'h0357, 0);
      chk("final_writes", wlog.size(), 21);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
